// File: rtl/zigzag_quant_8x8.sv
// rtl/zigzag_quant_8x8.sv - 8x8 shift quantizer with ping-pong zigzag reorder buffer
// Optional build macro QUANT_ROUND_EN: round half away from zero before the shift.
module zigzag_quant_8x8 #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int QS_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   input  logic [QS_W-1:0]         qshift,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data,
   output logic                    out_first,
   output logic                    out_last
);

   localparam logic [5:0] ZZ [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam logic signed [IN_W:0] QMAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] QMIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [OUT_W-1:0] mem [0:1][0:63];
   logic [QS_W-1:0]  qs [0:1];
   logic [1:0]       full;
   logic             wr_bank;
   logic             rd_bank;
   logic [5:0]       wr_cnt;
   logic [5:0]       rd_cnt;
   logic             run;
   logic             in_fire;
   logic             rd_load;
   logic [QS_W-1:0]  cur_qs;
   logic [OUT_W-1:0] q_data;

   // One extra bit of headroom keeps the most negative input representable after negation.
   function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] x, input logic [QS_W-1:0] s);
      logic signed [IN_W:0] ext;
      logic signed [IN_W:0] v;
`ifdef QUANT_ROUND_EN
      logic [IN_W:0] mag;
      logic [IN_W:0] half;
      logic [IN_W:0] m;
      ext  = $signed({x[IN_W-1], x});
      mag  = ext[IN_W] ? -ext : ext;
      half = (s == '0) ? '0 : ({{IN_W{1'b0}}, 1'b1} << (s - 1'b1));
      m    = (mag + half) >> s;
      v    = ext[IN_W] ? -$signed(m) : $signed(m);
`else
      ext = $signed({x[IN_W-1], x});
      v   = ext >>> s;
`endif
      if (v > QMAX)
         quant = QMAX[OUT_W-1:0];
      else if (v < QMIN)
         quant = QMIN[OUT_W-1:0];
      else
         quant = v[OUT_W-1:0];
   endfunction

   assign in_ready = run & ~full[wr_bank];
   assign in_fire  = in_valid & in_ready;
   assign rd_load  = full[rd_bank] & (~out_valid | out_ready);
   assign cur_qs   = (wr_cnt == 6'd0) ? qshift : qs[wr_bank];
   assign q_data   = quant(in_data, cur_qs);

   // Bank storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst && in_fire) begin
         mem[wr_bank][wr_cnt] <= q_data;
         if (wr_cnt == 6'd0)
            qs[wr_bank] <= qshift;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         run       <= 1'b0;
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= 6'd0;
         rd_cnt    <= 6'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         run <= 1'b1;
         if (in_fire) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd63) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end
         // A set and a clear on the same edge always address different banks.
         if (rd_load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_bank][ZZ[rd_cnt]];
            out_first <= (rd_cnt == 6'd0);
            out_last  <= (rd_cnt == 6'd63);
            rd_cnt    <= rd_cnt + 6'd1;
            if (rd_cnt == 6'd63) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= ~rd_bank;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_zigzag_quant_8x8.sv
// tb/tb_zigzag_quant_8x8.sv - scoreboard bench for zigzag_quant_8x8 with behavioural reference
module tb_zigzag_quant_8x8;
   localparam int IN_W  = 32;
   localparam int OUT_W = 16;
   localparam int QS_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic [QS_W-1:0]   qshift;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [OUT_W-1:0]  out_data;
   logic              out_first;
   logic              out_last;

   zigzag_quant_8x8 #(.IN_W(IN_W), .OUT_W(OUT_W), .QS_W(QS_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .qshift(qshift),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int mode = 0;          // 0: out_ready=1, 1: random, 2: out_ready=0
   int in_stall = 0;
   int accepted = 0;
   logic mon_en = 1'b0;
   logic [OUT_W+1:0] expq[$];
   logic signed [IN_W-1:0] blk[64];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic longint ref_q(input longint x, input int s);
      longint p, v, lim;
      p = longint'(1) << s;
`ifdef QUANT_ROUND_EN
      v = ((x < 0 ? -x : x) + (s != 0 ? p / 2 : 0)) / p;
      if (x < 0) v = -v;
`else
      if (x >= 0) v = x / p;
      else v = -((-x + p - 1) / p);
`endif
      lim = longint'(1) << (OUT_W - 1);
      if (v > lim - 1) v = lim - 1;
      if (v < -lim) v = -lim;
      return v;
   endfunction

   // Zigzag order by walking anti-diagonals, alternating direction.
   function automatic void push_block(input int s);
      int k;
      logic [OUT_W-1:0] d;
      k = 0;
      for (int sd = 0; sd < 15; sd++) begin
         int lo, hi;
         lo = (sd > 7) ? sd - 7 : 0;
         hi = (sd < 7) ? sd : 7;
         for (int j = 0; j <= hi - lo; j++) begin
            int r;
            r = (sd % 2 == 0) ? hi - j : lo + j;
            d = OUT_W'(ref_q(longint'(blk[r * 8 + (sd - r)]), s));
            expq.push_back({k == 0, k == 63, d});
            k++;
         end
      end
   endfunction

   task automatic send_n(input int n, input int s);
      logic done;
      for (int i = 0; i < n; i++) begin
         do begin
            @(negedge clk);
            in_valid = ($urandom_range(99) >= in_stall);
            in_data  = blk[i];
            qshift   = QS_W'(s);
            #1;
            done = in_valid && in_ready;
            @(posedge clk);
         end while (!done);
         accepted++;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic rand_block();
      for (int i = 0; i < 64; i++) begin
         case ($urandom_range(3))
            0: blk[i] = $signed($urandom);
            1: blk[i] = $signed($urandom_range(0, 2000)) - 1000;
            2: blk[i] = $signed($urandom_range(0, 400000)) - 200000;
            default: blk[i] = $signed($urandom_range(0, 65535)) - 32768;
         endcase
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 4000 && expq.size() != 0; t++) @(posedge clk);
      check("drain_empty", expq.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      do begin @(negedge clk); #1; t++; end while (!in_ready && t < 20);
      check("in_ready_after_reset", in_ready, 1);
   endtask

   // Monitor: pops the scoreboard on every accepted output word.
   logic held = 1'b0;
   logic [OUT_W+2:0] held_val;
   initial begin
      logic [OUT_W+1:0] e;
      forever begin
         @(negedge clk);
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
         #1;
         if (mon_en && rst) begin
            if (held) check("stall_hold", {out_valid, out_first, out_last, out_data}, held_val);
            if (out_valid && out_ready) begin
               if (expq.size() == 0) check("unexpected_out", 1, 0);
               else begin
                  e = expq.pop_front();
                  check("word", {out_first, out_last, out_data}, e);
               end
            end
            held = out_valid && !out_ready;
            held_val = {out_valid, out_first, out_last, out_data};
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      check("watchdog", 1, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      int qv;
      in_valid = 1'b0; in_data = '0; qshift = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_first", out_first, 0);
      check("rst_out_last", out_last, 0);
      rst = 1'b1;
      mon_en = 1'b1;
      wait_ready();

      // T1: ramp, pass-through, latency
      for (int i = 0; i < 64; i++) blk[i] = i;
      push_block(0);
      send_n(64, 0);
      idle(); #1;
      check("lat_idle", out_valid, 0);
      @(negedge clk); #1;
      check("lat_first", out_valid, 1);
      drain();

      // T2/T3: rounding and saturation corners, back to back
      for (int i = 0; i < 64; i++) blk[i] = -7;
      push_block(2); send_n(64, 2);
      for (int i = 0; i < 64; i++) blk[i] = 6;
      push_block(2); send_n(64, 2);
      for (int i = 0; i < 64; i++) blk[i] = (i % 2) ? -100000 : 100000;
      push_block(0); send_n(64, 0);
      idle();
      drain();

      // T4: output blocked, input must stall after two banks
      mode = 2;
      accepted = 0;
      fork
         for (int b = 0; b < 3; b++) begin
            rand_block(); qv = $urandom_range(15); push_block(qv); send_n(64, qv);
         end
         begin
            repeat (600) @(posedge clk);
            @(negedge clk); #1;
            check("t4_accepted", accepted, 128);
            check("t4_in_ready", in_ready, 0);
            mode = 0;
         end
      join
      idle();
      drain();

      // T5: random stalls on both sides
      mode = 1;
      in_stall = 30;
      for (int b = 0; b < 4; b++) begin
         rand_block(); qv = $urandom_range(15); push_block(qv); send_n(64, qv);
      end
      idle();
      drain();
      in_stall = 0;
      mode = 0;

      // T6: reset mid-block discards everything
      mode = 2;
      rand_block();
      send_n(64, 3);
      send_n(30, 3);
      idle(); #1;
      check("t6_word_pending", out_valid, 1);
      rst = 1'b0;
      @(negedge clk); #1;
      check("t6_out_valid", out_valid, 0);
      check("t6_in_ready", in_ready, 0);
      expq.delete();
      rst = 1'b1;
      mode = 0;
      wait_ready();
      rand_block(); qv = $urandom_range(15); push_block(qv); send_n(64, qv);
      idle();
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
